// File: rtl/lut_thru_pkg.sv
// Shared constants and helpers for the LUT-thru elastic register pipeline.
// Imported by the interface, the stage register and the pipeline top.
package lut_thru_pkg;

  // Upper bound on DEPTH accepted at elaboration.
  localparam int MAX_DEPTH = 64;

  // Width needed to hold an occupancy count of 0..depth.
  function automatic int clog2_cnt(input int depth);
    int w;
    w = 1;
    while ((1 << w) < (depth + 1)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/lut_thru_pipe_if.sv
// Upstream/downstream handshake bundle for lut_thru_pipe, plus the occupancy count.
// A word moves on a rising edge when valid && ready. ready may depend combinationally
// on the far side's ready. A held valid word must stay stable until it is taken.
interface lut_thru_pipe_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3
);
  import lut_thru_pkg::*;

  localparam int CW = clog2_cnt(DEPTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/lut_thru_stage.sv
// One elastic pipeline stage: a valid flag plus a data word.
// The stage can load when it is empty or when downstream is draining it this cycle.
module lut_thru_stage
  import lut_thru_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             C,
  input  logic             R,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  assign ready = !valid_q || dn_ready;
  assign valid = valid_q;
  assign data  = data_q;

  // Data only moves on a real load, so an emptied stage keeps showing its last word.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready) begin
      valid_d = up_valid;
      if (up_valid) begin
        data_d = up_data;
      end
    end
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/lut_thru_pipe.sv
// WIDTH x DEPTH elastic register pipeline with a buffer/inverter LUT in front of stage 0
// and an occupancy counter. in_ready is a combinational chain back from out_ready.
module lut_thru_pipe
  import lut_thru_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] INV_MASK  = '0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic          C,
  input  logic          R,
  lut_thru_pipe_if.slave bus
);

  localparam int CW = clog2_cnt(DEPTH);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("lut_thru_pipe: DEPTH must be in 1..MAX_DEPTH");
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;
    logic             dn_r;
    logic             rdy;
    logic             vld;
    logic [WIDTH-1:0] dat;

    if (k == 0) begin : g_head
      assign up_v = bus.in_valid;
      assign up_d = bus.in_data ^ INV_MASK;
    end else begin : g_body
      assign up_v = g_stage[k-1].vld;
      assign up_d = g_stage[k-1].dat;
    end

    if (k == DEPTH - 1) begin : g_tail
      assign dn_r = bus.out_ready;
    end else begin : g_mid
      assign dn_r = g_stage[k+1].rdy;
    end

    lut_thru_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .C        (C),
      .R        (R),
      .up_valid (up_v),
      .up_data  (up_d),
      .dn_ready (dn_r),
      .ready    (rdy),
      .valid    (vld),
      .data     (dat)
    );
  end

  logic          push;
  logic          pop;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign bus.in_ready  = g_stage[0].rdy;
  assign bus.out_valid = g_stage[DEPTH-1].vld;
  assign bus.out_data  = g_stage[DEPTH-1].dat;
  assign bus.count     = count_q;

  assign push = bus.in_valid && g_stage[0].rdy;
  assign pop  = g_stage[DEPTH-1].vld && bus.out_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: doc/lut_thru_pipe.md
Name: lut_thru_pipe

Overview:
Parametrised successor to the single-flop "free FF" LUT-thru test structure. A WIDTH-bit, DEPTH-stage elastic register pipeline with ready/valid flow control. Each bit of stage 0 is fed through a LUT acting as buffer or inverter, per a compile-time mask. It is instantiated inside interchange test tops between IB/OB buffers to exercise LUT-thru plus FF chains, clock-enable use and backpressure routing on the testarch.

Parameters:
WIDTH, 4, data bits per word (>=1)
DEPTH, 3, number of register stages (>=1; DEPTH=0 is illegal, elaboration error)
INV_MASK, {WIDTH{1'b0}}, per-bit invert applied before stage 0: bit=1 means inverter LUT, bit=0 means buffer LUT-thru
RESET_VAL, {WIDTH{1'b0}}, data value loaded into every stage on reset

Ports:
C  in  1  clock, rising edge
R  in  1  reset, asynchronous, active-high
in_valid  in  1  upstream word present
in_ready  out  1  pipeline accepts word this cycle
in_data  in  WIDTH  upstream word
out_valid  out  1  stage DEPTH-1 holds a word
out_ready  in  1  downstream accepts word this cycle
out_data  out  WIDTH  word in stage DEPTH-1
count  out  CW  occupied stages, 0..DEPTH; CW = clog2(DEPTH+1)

Behaviour:
- Interface: one clock C; reset R asynchronous, active-high. All state is cleared on R assertion, with no clock required.
- Reset values: every stage valid=0, data=RESET_VAL; out_valid=0, out_data=RESET_VAL, count=0. in_ready=1 during and after reset (combinational from empty stages).
- Per stage k: valid_k and data_k registers.
  - ready_k = !valid_k || ready_{k+1}; ready_DEPTH = out_ready.
- Stage k loads when ready_k is high and its upstream is valid. Upstream for k=0 is in_valid; for k>0 it is valid_{k-1}.
  - Stage 0 loads in_data ^ INV_MASK.
  - Stage k>0 loads data_{k-1}.
  - If ready_k is high and upstream is invalid, valid_k is cleared.
  - If ready_k is low, the stage holds.
- in_ready = ready_0. This is a combinational chain from out_ready; no skid buffer.
- out_valid = valid_{DEPTH-1}; out_data = data_{DEPTH-1}.
- Transfers: input transfer = in_valid && in_ready; output transfer = out_valid && out_ready.
- Latency: a word accepted at edge N appears on out_data after edge N+DEPTH-1, provided there are no stalls. It is visible for the cycle following that edge.
- Throughput: 1 word/cycle sustained when out_ready=1.
- Bubble collapse: empty stages fill even while the output is stalled. The pipeline holds DEPTH words max.
- Stability: while out_valid && !out_ready, out_data and out_valid are held unchanged.
- count update:
  - +1 on input transfer only.
  - -1 on output transfer only.
  - Unchanged on both or neither.
  - count never exceeds DEPTH and never underflows. This follows by construction; the bench asserts it.
- Full (count==DEPTH, out_ready=0): in_ready=0, and in_data is ignored.
- Full with out_ready=1: simultaneous push and pop, count stays DEPTH.
- Empty: out_valid=0, and out_data holds its last value (or RESET_VAL).
- Reset mid-operation: all words in flight are discarded. In-flight words are never emitted after R deasserts.
- The first input transfer after R deasserts is captured at the first rising edge with R low.

Decomposition:
- Package lut_thru_pkg: function clog2_cnt(depth) returning CW; localparam MAX_DEPTH=64 for assertion bounds.
- Sub-module lut_thru_stage: one valid+data register pair.
  - Parameters: WIDTH, RESET_VAL.
  - Ports: C, R, up_valid, up_data, dn_ready, ready, valid, data.
- lut_thru_pipe instantiates DEPTH of these stages in a generate loop, plus the input mask XOR and the count register.

Test Plan (WIDTH=4, DEPTH=3, INV_MASK=4'b0101 unless noted):
- Async reset: push 3 words, assert R between edges -> out_valid=0, count=0, out_data=4'h0 immediately. After release, in_ready=1.
- Streaming: out_ready=1, in_data=1,2,3,4 on consecutive edges -> out_data=4'h4,4'h7,4'h6,4'h1 on consecutive cycles. First word is valid after the 3rd edge; count stays 3 in steady state.
- Backpressure: out_ready=0, offer 4 words 8,9,A,B -> first 3 accepted, in_ready=0 on 4th, count=3. Raise out_ready -> D,C,F emitted in order, then B is accepted and emitted as E.
- Bubble collapse: out_ready=0, single word 4'h0 -> out_valid after the 3rd edge with out_data=4'h5, count=1, in_ready stays 1.
- Full push/pop: fill to count=3, then in_valid=out_ready=1 for 10 cycles -> count remains 3, 10 words out in input order, no drops or duplicates.
- Variant DEPTH=1, INV_MASK=4'hF: in 4'h3 -> out 4'hC after 1 edge; with out_ready=0, in_ready=0 while full.
